// File: rtl/cond_unit.sv
// Execute-stage condition unit: NZCV flag register, condition check, gating of write/branch controls into E->M.
// Latency: CondExE/BranchTakenE combinational; gated controls and flags registered, visible 1 cycle later.
// Backpressure: EnableE=0 holds all state (even with FlushE=1); FlushE=1 with EnableE=1 loads a bubble.
// Optional macro CONDFAIL_CNT_EN adds a saturating failed-condition counter on CondFailCount.
module cond_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EnableE,
  input  logic                 FlushE,
  input  logic [3:0]           CondE,
  input  logic [1:0]           FlagWriteE,
  input  logic [3:0]           ALUFlags,
  input  logic                 PCSrcE,
  input  logic                 RegWriteE,
  input  logic                 MemWriteE,
  input  logic                 BranchE,
  output logic                 CondExE,
  output logic                 BranchTakenE,
  output logic [3:0]           Flags,
  output logic                 PCSrcM,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic [CNT_WIDTH-1:0] CondFailCount
);

  logic [3:0] flags_q, flags_d;
  logic       pc_src_m_q, pc_src_m_d;
  logic       reg_write_m_q, reg_write_m_d;
  logic       mem_write_m_q, mem_write_m_d;
  logic       cond_pass;
  logic       flag_n, flag_z, flag_c, flag_v;

  // The check always looks at the registered flags, never this instruction's ALUFlags.
  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Decode the ARM condition field against the current flag register.
  always_comb begin
    cond_pass = 1'b1;
    case (CondE)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      default: cond_pass = 1'b1;  // AL and the unconditional encoding
    endcase
  end

  assign CondExE      = cond_pass & ~FlushE;
  assign BranchTakenE = BranchE & CondExE;

  // Next-state for flags and the E->M control register; a flush zeroes controls via CondExE.
  always_comb begin
    flags_d       = flags_q;
    pc_src_m_d    = pc_src_m_q;
    reg_write_m_d = reg_write_m_q;
    mem_write_m_d = mem_write_m_q;
    if (EnableE) begin
      if (CondExE) begin
        if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
        if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
      end
      pc_src_m_d    = (PCSrcE | BranchE) & CondExE;
      reg_write_m_d = RegWriteE & CondExE;
      mem_write_m_d = MemWriteE & CondExE;
    end
  end

  // Flag and pipeline registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q       <= 4'b0000;
      pc_src_m_q    <= 1'b0;
      reg_write_m_q <= 1'b0;
      mem_write_m_q <= 1'b0;
    end else begin
      flags_q       <= flags_d;
      pc_src_m_q    <= pc_src_m_d;
      reg_write_m_q <= reg_write_m_d;
      mem_write_m_q <= mem_write_m_d;
    end
  end

  assign Flags     = flags_q;
  assign PCSrcM    = pc_src_m_q;
  assign RegWriteM = reg_write_m_q;
  assign MemWriteM = mem_write_m_q;

`ifdef CONDFAIL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Count real (non-flushed, advancing) instructions whose condition failed; stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (EnableE && !FlushE && !cond_pass && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign CondFailCount = cnt_q;
`else
  assign CondFailCount = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: driver pushes reference-model expectations, monitor pops and compares.
// Inputs change on the falling edge; combinational outputs sampled mid-low-phase, registers 1ns after the rising edge.
// Optional macro CONDFAIL_CNT_EN must match the RTL build so the counter expectation is right.
`timescale 1ns/1ps
module tb_cond_unit;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          EnableE, FlushE, PCSrcE, RegWriteE, MemWriteE, BranchE;
  logic [3:0]    CondE, ALUFlags;
  logic [1:0]    FlagWriteE;
  logic          CondExE, BranchTakenE, PCSrcM, RegWriteM, MemWriteM;
  logic [3:0]    Flags;
  logic [CW-1:0] CondFailCount;

  cond_unit #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .EnableE(EnableE), .FlushE(FlushE), .CondE(CondE),
    .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .Flags(Flags), .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .CondFailCount(CondFailCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       cex;
    bit       btk;
    bit [3:0] flags;
    bit       pcs_m;
    bit       rw_m;
    bit       mw_m;
    int       cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: individual flags, M controls, and the fail count.
  bit m_n, m_z, m_c, m_v;
  bit m_pcs, m_rw, m_mw;
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Conditions 0-7 test one flag, odd codes invert it; 8-15 are the compound tests.
  function automatic bit cond_ok(input int c);
    bit sel[4];
    bit base;
    sel[0] = m_z; sel[1] = m_c; sel[2] = m_n; sel[3] = m_v;
    if (c < 8) begin
      base = sel[c / 2];
      return (c % 2 == 1) ? !base : base;
    end
    case (c)
      8:  return m_c && !m_z;
      9:  return !(m_c && !m_z);
      10: return m_n == m_v;
      11: return m_n != m_v;
      12: return !m_z && (m_n == m_v);
      13: return !(!m_z && (m_n == m_v));
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    {m_n, m_z, m_c, m_v} = 4'b0000;
    m_pcs = 0; m_rw = 0; m_mw = 0; m_cnt = 0;
  endtask

  // Drive one E-stage instruction, then predict the outcome and queue it.
  task automatic issue(input bit en, input bit fl, input int cond, input int fw, input int alu,
                       input bit pcs, input bit rw, input bit mw, input bit br);
    exp_t e;
    bit   pass, go;
    @(negedge clk);
    EnableE = en; FlushE = fl; CondE = 4'(cond); FlagWriteE = 2'(fw); ALUFlags = 4'(alu);
    PCSrcE = pcs; RegWriteE = rw; MemWriteE = mw; BranchE = br;
    #2;
    pass  = cond_ok(cond);
    go    = pass && !fl;
    e.cex = go;
    e.btk = br && go;
    if (en) begin
      if (go && (fw / 2 == 1)) begin m_n = alu[3]; m_z = alu[2]; end
      if (go && (fw % 2 == 1)) begin m_c = alu[1]; m_v = alu[0]; end
      m_pcs = (pcs || br) && go;
      m_rw  = rw && go;
      m_mw  = mw && go;
`ifdef CONDFAIL_CNT_EN
      if (!fl && !pass && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
    end
    e.flags = {m_n, m_z, m_c, m_v};
    e.pcs_m = m_pcs; e.rw_m = m_rw; e.mw_m = m_mw; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  // Asynchronous reset pulse in the middle of the low phase; outputs must clear before any edge.
  task automatic mid_reset();
    @(negedge clk);
    EnableE = 0; FlushE = 1;
    #3 reset = 1'b0;
    #1;
    chk("rst_flags", 32'(Flags), 0);
    chk("rst_pcsm", 32'(PCSrcM), 0);
    chk("rst_rwm", 32'(RegWriteM), 0);
    chk("rst_mwm", 32'(MemWriteM), 0);
    chk("rst_cnt", 32'(CondFailCount), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: pops one expectation per issued instruction and compares it.
  initial begin
    exp_t r;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("CondExE", 32'(CondExE), 32'(r.cex));
        chk("BranchTakenE", 32'(BranchTakenE), 32'(r.btk));
        @(posedge clk);
        #1;
        chk("Flags", 32'(Flags), 32'(r.flags));
        chk("PCSrcM", 32'(PCSrcM), 32'(r.pcs_m));
        chk("RegWriteM", 32'(RegWriteM), 32'(r.rw_m));
        chk("MemWriteM", 32'(MemWriteM), 32'(r.mw_m));
        chk("CondFailCount", 32'(CondFailCount), 32'(r.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    EnableE = 0; FlushE = 0; CondE = 0; FlagWriteE = 0; ALUFlags = 0;
    PCSrcE = 0; RegWriteE = 0; MemWriteE = 0; BranchE = 0;
    model_reset();
    #7;
    chk("init_flags", 32'(Flags), 0);
    chk("init_pcsm", 32'(PCSrcM), 0);
    chk("init_rwm", 32'(RegWriteM), 0);
    chk("init_mwm", 32'(MemWriteM), 0);
    chk("init_cnt", 32'(CondFailCount), 0);
    @(negedge clk);
    reset = 1'b1;

    //    en fl cond fw alu   pcs rw mw br
    issue(1, 0, 14, 3, 4'b0100, 0, 1, 0, 0);  // AL, write all flags -> 0100
    issue(1, 0, 0,  0, 0,       0, 0, 0, 1);  // EQ branch taken
    issue(1, 0, 1,  0, 0,       1, 1, 1, 1);  // NE fails, all gated off
    issue(1, 0, 14, 3, 4'b0000, 0, 0, 0, 0);  // clear flags
    issue(1, 0, 14, 2, 4'b1011, 0, 0, 0, 0);  // N,Z only -> 1000
    issue(1, 0, 14, 1, 4'b0011, 0, 0, 0, 0);  // C,V only -> 1011
    issue(1, 0, 14, 3, 4'b1001, 0, 0, 0, 0);
    issue(1, 0, 10, 0, 0,       0, 1, 0, 0);  // GE pass
    issue(1, 0, 14, 3, 4'b1000, 0, 0, 0, 0);
    issue(1, 0, 11, 0, 0,       0, 1, 0, 0);  // LT pass
    issue(1, 0, 14, 3, 4'b1100, 0, 0, 0, 0);
    issue(1, 0, 12, 0, 0,       0, 1, 1, 0);  // GT fail
    issue(1, 0, 13, 0, 0,       0, 1, 1, 0);  // LE pass
    for (int i = 0; i < 3; i++) issue(0, 0, 14, 3, 4'b0011, 0, 1, 0, 0);  // stall holds
    issue(0, 1, 14, 3, 4'b0011, 1, 1, 1, 1);  // stall with flush still holds
    issue(1, 1, 14, 3, 4'b0011, 0, 1, 0, 0);  // flush: bubble, no flag write
    issue(1, 0, 14, 3, 4'b0000, 0, 0, 0, 0);  // Z=0
    for (int i = 0; i < 5; i++) issue(1, 0, 0, 0, 0, 0, 1, 0, 0);  // five EQ fails
    issue(1, 1, 0, 0, 0, 0, 1, 0, 0);         // flushed fail not counted
    issue(1, 0, 0, 0, 0, 0, 1, 0, 0);
    mid_reset();

    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(9, 0) != 0, $urandom_range(6, 0) == 0, $urandom_range(15, 0),
            $urandom_range(3, 0), $urandom_range(15, 0), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      if (i == 200) mid_reset();
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage condition unit of the pipelined ARM core. Sits directly downstream of the ALU and consumes its ALUFlags {N,Z,C,V}.
- Holds the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against it.
- Gates the instruction's write and branch controls, then registers the gated controls into the E→M pipeline boundary.
- Supports stall (hold) and flush (bubble).

Parameters:
- CNT_WIDTH, 16, width of the optional condition-fail counter

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low; asserted (0) clears all state
- EnableE  in  1  1 = E stage advances; 0 = stall, all state held
- FlushE  in  1  1 = instruction in E is killed (treated as bubble)
- CondE  in  4  ARM condition field of instruction in E
- FlagWriteE  in  2  [1] = write N,Z; [0] = write C,V
- ALUFlags  in  4  {N,Z,C,V} from ALU, same cycle
- PCSrcE  in  1  instruction writes PC
- RegWriteE  in  1  instruction writes register file
- MemWriteE  in  1  instruction writes memory
- BranchE  in  1  instruction is a branch
- CondExE  out  1  combinational: condition passed and not flushed
- BranchTakenE  out  1  combinational: BranchE & CondExE
- Flags  out  4  registered NZCV
- PCSrcM  out  1  registered gated PCSrc
- RegWriteM  out  1  registered gated RegWrite
- MemWriteM  out  1  registered gated MemWrite
- CondFailCount  out  CNT_WIDTH  condition-fail count (optional feature)

Behaviour:
- Reset (reset=0, async): Flags=4'b0000, PCSrcM=RegWriteM=MemWriteM=0, CondFailCount=0. The first edge after release behaves normally.
- Condition evaluation uses the current Flags register value, never the ALUFlags of the same instruction.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: 1 (treated as AL)
- CondExE = CondPass & ~FlushE. It is independent of EnableE.
- Flag update at a rising edge requires EnableE=1, FlushE=0 and CondExE=1:
  - FlagWriteE[1] → Flags[3:2] <= ALUFlags[3:2].
  - FlagWriteE[0] → Flags[1:0] <= ALUFlags[1:0].
  - Each half is updated independently; any half not selected holds.
- Pipeline register, when EnableE=1:
  - PCSrcM <= (PCSrcE|BranchE)&CondExE.
  - RegWriteM <= RegWriteE&CondExE.
  - MemWriteM <= MemWriteE&CondExE.
  - With FlushE=1 all three load 0 (bubble).
- When EnableE=0: Flags and all M-registers hold, including when FlushE=1.
- Latency: gated controls appear at the M outputs 1 cycle after E. Flag results are visible to the next instruction's condition check 1 cycle later, so back-to-back CMP;BEQ needs no forwarding.
- Failed condition: no flag write; all gated controls 0; the instruction still advances as a no-op.
- A reset asserted mid-stall or mid-flush overrides everything.

Optional Feature:
- Macro: CONDFAIL_CNT_EN.
- Defined:
  - CondFailCount increments by 1 at each rising edge with EnableE=1, FlushE=0 and CondPass=0.
  - It saturates at all-ones and is cleared only by reset.
- Undefined: no counter register; CondFailCount is tied to 0; port list unchanged.

Test Plan:
- Reset, then release; CondE=1110, FlagWriteE=2'b11, ALUFlags=4'b0100, EnableE=1 → after edge Flags=0100; CondExE=1 throughout.
- Flags=0100; CondE=0000, BranchE=1 → CondExE=1, BranchTakenE=1, PCSrcM=1 next edge. Repeat with CondE=0001 → all gated outputs 0, Flags unchanged.
- Flags=0000; FlagWriteE=2'b10, ALUFlags=4'b1011 → Flags=1000 (C,V kept 0). Then FlagWriteE=2'b01, ALUFlags=4'b0011 → Flags=1011.
- Flags=1001 (N=1,V=1); CondE=1010 GE → pass. Flags=1000; CondE=1011 LT → pass. Flags=1100; CondE=1100 GT → fail. Flags=1100; CondE=1101 LE → pass.
- EnableE=0 with RegWriteE=1, FlagWriteE=2'b11 for 3 cycles → Flags and RegWriteM held. FlushE=1, EnableE=1 → RegWriteM=0, no flag write, CondExE=0.
- With CONDFAIL_CNT_EN: 5 failing instructions (CondE=0000, Z=0), then a flushed failing one → CondFailCount=5. Reset low mid-sequence → all outputs 0 immediately, without waiting for a clock edge.
